// File: rtl/dcount_monitor.sv
// dcount_monitor: scoreboard for a WIDTH-bit down-counter stage.
// Predicts each counter sample from the previous sample and enable.
// It then reports lock, mismatch pulses, saturating error and wrap counts,
// and the first failing sample.
//
// Optional feature macro: DCOUNT_MON_HALT_EN. When defined, the first
// mismatch in TRACK parks the FSM in HALT until clr or rst.
//
// Ports:
//   clock      system clock, rising edge
//   rst        asynchronous reset, active-high
//   cnt_rdy    ready from the counter stage
//   cnt_en     enable as presented to the counter stage
//   cnt_val    counter value output
//   clr        synchronous clear of statistics
//   locked     high while tracking
//   err        one-cycle pulse per detected mismatch (latency 1)
//   fault      sticky, set on first mismatch since reset or clr
//   err_cnt    saturating mismatch count
//   wrap_cnt   saturating count of enabled underflows
//   first_bad  cnt_val at first mismatch
//   first_exp  expected value at first mismatch
module dcount_monitor #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned STEP       = 1,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned WRAP_CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  cnt_rdy,
    input  logic                  cnt_en,
    input  logic [WIDTH-1:0]      cnt_val,
    input  logic                  clr,
    output logic                  locked,
    output logic                  err,
    output logic                  fault,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WRAP_CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]      first_bad,
    output logic [WIDTH-1:0]      first_exp
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

`ifdef DCOUNT_MON_HALT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2, HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2} state_t;
`endif

    state_t                  state, state_n;
    logic [WIDTH-1:0]        prev_val, prev_val_n;
    logic                    prev_en, prev_en_n;
    logic                    locked_n, err_n, fault_n;
    logic [ERR_CNT_W-1:0]    err_cnt_n;
    logic [WRAP_CNT_W-1:0]   wrap_cnt_n;
    logic [WIDTH-1:0]        first_bad_n, first_exp_n;
    logic [WIDTH-1:0]        exp_val;
    logic                    mismatch;

    // Prediction from the previous sample (modulo 2^WIDTH)
    assign exp_val  = prev_en ? (prev_val - STEP_V) : prev_val;
    assign mismatch = (cnt_val != exp_val);

    // State and statistics registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prev_val  <= '0;
            prev_en   <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            fault     <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
            first_bad <= '0;
            first_exp <= '0;
        end else begin
            state     <= state_n;
            prev_val  <= prev_val_n;
            prev_en   <= prev_en_n;
            locked    <= locked_n;
            err       <= err_n;
            fault     <= fault_n;
            err_cnt   <= err_cnt_n;
            wrap_cnt  <= wrap_cnt_n;
            first_bad <= first_bad_n;
            first_exp <= first_exp_n;
        end
    end

    // Next-state, compare and statistics update
    always_comb begin
        state_n     = state;
        prev_val_n  = prev_val;
        prev_en_n   = prev_en;
        err_n       = 1'b0;
        fault_n     = fault;
        err_cnt_n   = err_cnt;
        wrap_cnt_n  = wrap_cnt;
        first_bad_n = first_bad;
        first_exp_n = first_exp;

        case (state)
            IDLE: begin
                if (cnt_rdy) state_n = ARM;
            end
            ARM: begin
                if (!cnt_rdy) begin
                    state_n = IDLE;
                end else begin
                    prev_val_n = cnt_val;
                    prev_en_n  = cnt_en;
                    state_n    = TRACK;
                end
            end
            TRACK: begin
                if (!cnt_rdy) begin
                    state_n = IDLE;
                end else begin
                    // Resync to the observed value so one glitch costs at most two errors
                    prev_val_n = cnt_val;
                    prev_en_n  = cnt_en;
                    if (mismatch) begin
                        err_n = 1'b1;
                        if (err_cnt != '1) err_cnt_n = err_cnt + ERR_CNT_W'(1);
                        if (!fault) begin
                            fault_n     = 1'b1;
                            first_bad_n = cnt_val;
                            first_exp_n = exp_val;
                        end
`ifdef DCOUNT_MON_HALT_EN
                        if (!clr) state_n = HALT;
`endif
                    end else if (prev_en && (prev_val < STEP_V) && (wrap_cnt != '1)) begin
                        wrap_cnt_n = wrap_cnt + WRAP_CNT_W'(1);
                    end
                end
            end
`ifdef DCOUNT_MON_HALT_EN
            HALT: begin
                if (clr) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase

        // clr overrides any same-cycle statistics update; err still pulses
        if (clr) begin
            fault_n     = 1'b0;
            err_cnt_n   = '0;
            wrap_cnt_n  = '0;
            first_bad_n = '0;
            first_exp_n = '0;
        end

        locked_n = (state_n == TRACK);
    end

endmodule
